// File: rtl/logic_unit_mc_if.sv
// Handshake and data bundle for the multi-cycle bitwise logic unit.
// Names mirror the block's external pin list.
interface logic_unit_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] O;
    logic             zero;
    logic             err;

    modport master (
        output start, op, A, B,
        input  busy, done, O, zero, err
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, O, zero, err
    );
endinterface

// File: rtl/logic_unit_mc.sv
// Multi-cycle bitwise logic unit: evaluates op on SLICE bits per cycle over WIDTH-bit operands,
// publishing O/zero/err only once the whole word is complete.
module logic_unit_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic           clk,
    input  logic           rst,
    logic_unit_mc_if.slave bus_io
);
    localparam int unsigned N = WIDTH / SLICE;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d, o_q, o_d;
    logic [2:0]       op_q, op_d;
    logic             zero_q, zero_d, err_q, err_d;
    logic [SLICE-1:0] a_sl, b_sl, r_sl;

    assign a_sl = a_q[cnt_q*SLICE +: SLICE];
    assign b_sl = b_q[cnt_q*SLICE +: SLICE];

    // Reserved codes fall through to an all-zero slice.
    always_comb begin
        case (op_q)
            3'b000:  r_sl = a_sl & b_sl;
            3'b001:  r_sl = a_sl | b_sl;
            3'b010:  r_sl = a_sl ^ b_sl;
            3'b011:  r_sl = ~(a_sl | b_sl);
            3'b100:  r_sl = a_sl & ~b_sl;
            default: r_sl = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        work_d  = work_q;
        o_d     = o_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    a_d     = bus_io.A;
                    b_d     = bus_io.B;
                    op_d    = bus_io.op;
                    cnt_d   = '0;
                    work_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                work_d[cnt_q*SLICE +: SLICE] = r_sl;
                // O/zero/err are published only from the fully assembled word.
                if (cnt_q == LastCnt) begin
                    o_d     = work_d;
                    zero_d  = (work_d == '0);
                    err_d   = (op_q >= 3'b101);
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            work_q  <= '0;
            o_q     <= '0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            work_q  <= work_d;
            o_q     <= o_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign bus_io.busy = (state_q != StIdle);
    assign bus_io.done = (state_q == StDone);
    assign bus_io.O    = o_q;
    assign bus_io.zero = zero_q;
    assign bus_io.err  = err_q;
endmodule
